// File: rtl/reception_pkg.sv
// Shared codes for the reception desk query/message protocol.
// Used by the patient-side issuer and its testbench.
package reception_pkg;

  typedef enum logic [1:0] {
    MSG_NONE = 2'd0,
    MSG_DOC1 = 2'd1,
    MSG_DOC2 = 2'd2,
    MSG_WAIT = 2'd3
  } msg_e;

  typedef enum logic [1:0] {
    Q_REQ  = 2'b00,
    Q_REL1 = 2'b01,
    Q_REL2 = 2'b10
  } query_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    BACKOFF,
    RELEASE
  } state_e;

endpackage

// File: rtl/reception_query_issuer_fifo.sv
// Synchronous patient token FIFO with occupancy count.
// A push and a pop may land in the same cycle, even when the FIFO is full.
module patient_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rptr];

  // NOTE: storage is deliberately not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reception_query_issuer.sv
// Patient-side initiator: queues arrivals, issues one doctor request at a time,
// retries after back-off, and forwards doctor releases ahead of queued requests.
module reception_query_issuer
  import reception_pkg::*;
#(
  parameter int QUEUE_DEPTH  = 4,
  parameter int TOKEN_W      = 4,
  parameter int RETRY_WAIT   = 20,
  parameter int RESP_TIMEOUT = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           arrive,
  input  logic                           release_req,
  input  logic                           release_doc,
  input  logic [1:0]                     message,
  output logic                           start,
  output logic [1:0]                     query,
  output logic                           allot_valid,
  output logic [1:0]                     allot_doctor,
  output logic [TOKEN_W-1:0]             allot_token,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic                           queue_full,
  output logic                           timeout_err
);

  localparam int TIMER_MAX = (RETRY_WAIT > RESP_TIMEOUT) ? RETRY_WAIT : RESP_TIMEOUT;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  state_e               state;
  query_e               query_q;
  logic [TIMER_W-1:0]   timer;
  logic [TOKEN_W-1:0]   token_cnt;
  logic [TOKEN_W-1:0]   head_token;
  logic                 pend_valid;
  logic                 pend_doc;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 got_doctor;

  assign got_doctor = (message == MSG_DOC1) || (message == MSG_DOC2);
  assign pop        = (state == WAIT_RESP) && got_doctor;
  assign push       = arrive && (!queue_full || pop);
  assign query      = query_q;

  patient_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .W     (TOKEN_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (token_cnt),
    .rdata (head_token),
    .count (queue_count),
    .full  (queue_full),
    .empty (fifo_empty)
  );

  // Tokens only advance when an arrival is actually accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) token_cnt <= '0;
    else if (push) token_cnt <= token_cnt + 1'b1;
  end

  // A fresh release_req wins over clearing, so a release in the decision cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_doc   <= 1'b0;
    end else if (release_req) begin
      pend_valid <= 1'b1;
      pend_doc   <= release_doc;
    end else if (state == IDLE && pend_valid) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      start        <= 1'b0;
      query_q      <= Q_REQ;
      allot_valid  <= 1'b0;
      allot_doctor <= '0;
      allot_token  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle so every strobe lasts exactly one clock.
      start        <= 1'b0;
      query_q      <= Q_REQ;
      allot_valid  <= 1'b0;
      allot_doctor <= '0;
      allot_token  <= '0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_valid) begin
            state   <= RELEASE;
            start   <= 1'b1;
            query_q <= pend_doc ? Q_REL2 : Q_REL1;
          end else if (!fifo_empty) begin
            state <= ISSUE;
            start <= 1'b1;
          end
        end
        RELEASE: state <= IDLE;
        ISSUE: begin
          state <= WAIT_RESP;
          timer <= '0;
        end
        WAIT_RESP: begin
          if (got_doctor) begin
            allot_valid  <= 1'b1;
            allot_doctor <= message;
            allot_token  <= head_token;
            state        <= IDLE;
          end else if (message == MSG_WAIT) begin
            state <= BACKOFF;
            timer <= '0;
          end else if (timer == TIMER_W'(RESP_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= BACKOFF;
            timer       <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        BACKOFF: begin
          if (timer == TIMER_W'(RETRY_WAIT - 1)) state <= IDLE;
          else timer <= timer + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reception_query_issuer.sv
// Directed protocol scenarios followed by a randomized allocator/arrival run
// checked against a queue-based model of tokens and allotments.
module tb_reception_query_issuer;

  localparam int DEPTH   = 4;
  localparam int TOKW    = 4;
  localparam int RETRY   = 20;
  localparam int RTO     = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             arrive;
  logic             release_req;
  logic             release_doc;
  logic [1:0]       message;
  logic             start;
  logic [1:0]       query;
  logic             allot_valid;
  logic [1:0]       allot_doctor;
  logic [TOKW-1:0]  allot_token;
  logic [2:0]       queue_count;
  logic             queue_full;
  logic             timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  reception_query_issuer #(
    .QUEUE_DEPTH  (DEPTH),
    .TOKEN_W      (TOKW),
    .RETRY_WAIT   (RETRY),
    .RESP_TIMEOUT (RTO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arrive       (arrive),
    .release_req  (release_req),
    .release_doc  (release_doc),
    .message      (message),
    .start        (start),
    .query        (query),
    .allot_valid  (allot_valid),
    .allot_doctor (allot_doctor),
    .allot_token  (allot_token),
    .queue_count  (queue_count),
    .queue_full   (queue_full),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int max, output int n, output bit found);
    n = 0;
    found = 1'b0;
    while (n < max && !found) begin
      tick();
      n++;
      if (start) found = 1'b1;
    end
  endtask

  task automatic reply_and_check(input logic [1:0] doc, input int tok, input string tag);
    tick();
    message = doc;
    tick();
    message = 2'd0;
    check({tag, "_valid"}, allot_valid, 1);
    check({tag, "_doc"}, allot_doctor, doc);
    check({tag, "_tok"}, allot_token, tok);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_start"}, start, 0);
    check({tag, "_query"}, query, 0);
    check({tag, "_allot"}, allot_valid, 0);
    check({tag, "_adoc"}, allot_doctor, 0);
    check({tag, "_atok"}, allot_token, 0);
    check({tag, "_count"}, queue_count, 0);
    check({tag, "_full"}, queue_full, 0);
    check({tag, "_tmo"}, timeout_err, 0);
  endtask

  initial begin
    int  n;
    bit  f;
    int  model_q[$];
    int  tok;
    bit  awaiting;
    int  wcnt;
    logic [1:0] rep;
    bit  exp_allot;
    int  exp_doc;
    int  exp_tok;

    // 1: reset with arrive held high
    rst_n = 1'b0; arrive = 1'b1; release_req = 1'b0; release_doc = 1'b0; message = 2'd0;
    tick(); tick();
    check_idle_outputs("rst");
    rst_n = 1'b1; arrive = 1'b0;
    tick();

    // 2: single arrival, doctor 1 answers two cycles after start
    arrive = 1'b1;
    tick();
    arrive = 1'b0;
    check("t2_count1", queue_count, 1);
    check("t2_nostart", start, 0);
    tick();
    check("t2_start", start, 1);
    check("t2_query", query, 0);
    tick();
    check("t2_start_drop", start, 0);
    reply_and_check(2'd1, 0, "t2");
    check("t2_count0", queue_count, 0);
    tick();
    check("t2_pulse", allot_valid, 0);

    // 3: wait reply, then doctor 2 on the retry
    arrive = 1'b1; tick(); arrive = 1'b0;
    wait_start(10, n, f);
    check("t3_found", f, 1);
    check("t3_lat", n, 1);
    tick();
    message = 2'd3;
    tick();
    message = 2'd0;
    wait_start(60, n, f);
    check("t3_refound", f, 1);
    check("t3_retry_gap", n + 1, 1 + RETRY + 1);
    reply_and_check(2'd2, 1, "t3");

    // 4: no reply -> timeout, then re-issue after back-off
    arrive = 1'b1; tick(); arrive = 1'b0;
    wait_start(10, n, f);
    check("t4_found", f, 1);
    n = 0;
    while (n < 40 && !timeout_err) begin
      tick();
      n++;
    end
    check("t4_tmo_seen", timeout_err, 1);
    check("t4_tmo_gap", n, RTO + 1);
    wait_start(60, n, f);
    check("t4_refound", f, 1);
    check("t4_reissue_gap", n, RETRY + 1);
    reply_and_check(2'd1, 2, "t4");

    // 5: fresh reset, five arrivals into a four-deep queue
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    f = 1'b0;
    arrive = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (start) f = 1'b1;
    end
    arrive = 1'b0;
    check("t5_first_start", f, 1);
    check("t5_full", queue_full, 1);
    check("t5_count", queue_count, DEPTH);
    message = 2'd1;
    tick();
    message = 2'd0;
    check("t5_tok0", allot_token, 0);
    check("t5_notfull", queue_full, 0);
    for (int k = 1; k < 4; k++) begin
      wait_start(10, n, f);
      check("t5_found", f, 1);
      reply_and_check(2'd1, k, "t5");
    end
    check("t5_drained", queue_count, 0);
    arrive = 1'b1; tick(); arrive = 1'b0;
    wait_start(10, n, f);
    reply_and_check(2'd2, 4, "t5_after_drop");

    // 6: release during back-off served first; reset mid-WAIT_RESP
    arrive = 1'b1; tick(); arrive = 1'b0;
    wait_start(10, n, f);
    tick();
    message = 2'd3;
    tick();
    message = 2'd0;
    repeat (5) tick();
    release_req = 1'b1; release_doc = 1'b0;
    tick();
    release_req = 1'b0;
    wait_start(60, n, f);
    check("t6_rel_found", f, 1);
    check("t6_rel_query", query, 1);
    wait_start(10, n, f);
    check("t6_req_found", f, 1);
    check("t6_req_query", query, 0);
    tick(); tick();
    rst_n = 1'b0;
    #2;
    check_idle_outputs("t6_rst");
    tick();
    rst_n = 1'b1;
    wait_start(10, n, f);
    check("t6_no_start", f, 0);

    // Randomized arrivals and allocator replies against a token-queue model
    tok = 0; awaiting = 1'b0; wcnt = 0; exp_allot = 1'b0; exp_doc = 0; exp_tok = 0;
    for (int c = 0; c < 1500; c++) begin
      check("rnd_allot", allot_valid, exp_allot);
      if (exp_allot) begin
        check("rnd_doc", allot_doctor, exp_doc);
        check("rnd_tok", allot_token, exp_tok);
      end
      check("rnd_tmo", timeout_err, 0);
      check("rnd_count", queue_count, model_q.size());
      check("rnd_full", queue_full, model_q.size() == DEPTH);
      if (start) begin
        check("rnd_query", query, 0);
        check("rnd_overlap", awaiting, 0);
        awaiting = 1'b1;
        wcnt = $urandom_range(3, 1);
      end
      rep = 2'd0;
      if (awaiting) begin
        if (wcnt == 0) begin
          rep = 2'($urandom_range(3, 1));
          awaiting = 1'b0;
        end else begin
          wcnt--;
        end
      end
      message = rep;
      arrive = ($urandom_range(2, 0) == 0);
      exp_allot = (rep == 2'd1 || rep == 2'd2);
      if (exp_allot) begin
        exp_doc = rep;
        exp_tok = model_q.pop_front();
      end
      if (arrive && model_q.size() < DEPTH) begin
        model_q.push_back(tok);
        tok = (tok + 1) % (1 << TOKW);
      end
      tick();
    end
    arrive = 1'b0;
    message = 2'd0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
